// File: rtl/cabac_byte_feeder.sv
// Byte supply stage for the CABAC arithmetic decoder.
// A small first-word-fall-through FIFO buffers slice-data bytes from the
// bitstream reader. On start the first two bytes are popped to seed m_value
// (init_value); after that one byte is delivered per renormalisation request.
// A request that finds the FIFO empty is remembered (pending) and the decoder
// is told to stall until a byte arrives.
module cabac_byte_feeder #(
  parameter int DEPTH = 4,   // FIFO depth in bytes, power of 2, >= 2
  parameter int CNT_W = 24   // width of the consumed-byte counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             request_byte,
  output logic [7:0]       byte_out,
  output logic             byte_strobe,
  output logic [15:0]      init_value,
  output logic             init_done,
  output logic             stall,
  output logic             req_err,
  output logic [CNT_W-1:0] bytes_consumed
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT0 = 2'd1,
    S_INIT1 = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Delivery side state
  logic             pending_q, pending_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_strobe_q, byte_strobe_d;
  logic [15:0]      init_value_q, init_value_d;
  logic             init_done_q, init_done_d;
  logic             req_err_q, req_err_d;
  logic [CNT_W-1:0] consumed_q, consumed_d;

  // Derived control
  logic       empty, full, push, pop, consume, want;
  logic [7:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr_q];
  assign want  = request_byte | pending_q;

  // A pop in the same cycle does not make room: in_ready looks only at the
  // registered count, so it never depends on request_byte.
  assign push  = in_valid & ~full & ~flush;

  // State register.
  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every flop samples the pre-edge values of all other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: flush wins over everything; start is honoured only in
  // IDLE and RUN; the init states advance one step per available byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start)  state_d = S_INIT0;
        S_INIT0: if (!empty) state_d = S_INIT1;
        S_INIT1: if (!empty) state_d = S_RUN;
        S_RUN:   if (start)  state_d = S_INIT0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/control decode: which cycles pop the FIFO, and when to stall.
  always_comb begin
    pop     = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      S_INIT0, S_INIT1: pop = ~empty;
      S_RUN: begin
        // A restart in RUN drops any same-cycle request.
        consume = want & ~empty & ~start;
        pop     = consume;
      end
      default: ;
    endcase
    if (flush) begin
      pop     = 1'b0;
      consume = 1'b0;
    end
  end

  assign stall = (state_q == S_RUN) & want & empty;

  // FIFO storage write port.
  // NOTE: the byte array carries no reset; count and pointers define which
  // entries are meaningful, so resetting the storage would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_byte;
  end

  // Next values for FIFO pointers and the delivery registers.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pending_d     = pending_q;
    byte_out_d    = byte_out_q;
    byte_strobe_d = consume;
    init_value_d  = init_value_q;
    init_done_d   = pop & (state_q == S_INIT1);
    req_err_d     = req_err_q;
    consumed_d    = consumed_q;

    if (flush) begin
      // init_value, byte_out and the counter keep their last values.
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pending_d = 1'b0;
      req_err_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);

      if (request_byte && state_q != S_RUN) req_err_d = 1'b1;

      if (state_q == S_RUN) begin
        if (start || consume)          pending_d = 1'b0;
        else if (request_byte && empty) pending_d = 1'b1;
      end else begin
        pending_d = 1'b0;
      end

      if (consume) byte_out_d = head;
      if (pop && state_q == S_INIT0) init_value_d[15:8] = head;
      if (pop && state_q == S_INIT1) init_value_d[7:0]  = head;

      if (start && (state_q == S_IDLE || state_q == S_RUN))
        consumed_d = '0;
      else if (pop)
        consumed_d = consumed_q + CNT_W'(1);
    end
  end

  // Register bank for FIFO pointers and delivery outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pending_q     <= 1'b0;
      byte_out_q    <= '0;
      byte_strobe_q <= 1'b0;
      init_value_q  <= '0;
      init_done_q   <= 1'b0;
      req_err_q     <= 1'b0;
      consumed_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pending_q     <= pending_d;
      byte_out_q    <= byte_out_d;
      byte_strobe_q <= byte_strobe_d;
      init_value_q  <= init_value_d;
      init_done_q   <= init_done_d;
      req_err_q     <= req_err_d;
      consumed_q    <= consumed_d;
    end
  end

  assign in_ready       = ~full;
  assign byte_out       = byte_out_q;
  assign byte_strobe    = byte_strobe_q;
  assign init_value     = init_value_q;
  assign init_done      = init_done_q;
  assign req_err        = req_err_q;
  assign bytes_consumed = consumed_q;

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// Self-checking bench for cabac_byte_feeder: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_cabac_byte_feeder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush, start, in_valid, request_byte;
  logic [7:0]       in_byte;
  logic             in_ready, byte_strobe, init_done, stall, req_err;
  logic [7:0]       byte_out;
  logic [15:0]      init_value;
  logic [CNT_W-1:0] bytes_consumed;

  cabac_byte_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .start          (start),
    .in_byte        (in_byte),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .request_byte   (request_byte),
    .byte_out       (byte_out),
    .byte_strobe    (byte_strobe),
    .init_value     (init_value),
    .init_done      (init_done),
    .stall          (stall),
    .req_err        (req_err),
    .bytes_consumed (bytes_consumed)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a byte queue, an "active" flag with a count of init
  // bytes still owed, and the single outstanding-request flag.
  logic [7:0]       m_q[$];
  bit               m_active;
  int               m_init_need;
  bit               m_pending, m_req_err, m_strobe, m_done;
  logic [7:0]       m_byte_out;
  logic [15:0]      m_init_value;
  logic [CNT_W-1:0] m_consumed;

  function automatic void model_reset();
    m_q.delete();
    m_active     = 1'b0;
    m_init_need  = 0;
    m_pending    = 1'b0;
    m_req_err    = 1'b0;
    m_strobe     = 1'b0;
    m_done       = 1'b0;
    m_byte_out   = '0;
    m_init_value = '0;
    m_consumed   = '0;
  endfunction

  function automatic bit m_running();
    return m_active && (m_init_need == 0);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    bit         can_push = (m_q.size() < DEPTH);
    bit         want     = request_byte || m_pending;
    logic [7:0] b;
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (flush) begin
      m_q.delete();
      m_active    = 1'b0;
      m_init_need = 0;
      m_pending   = 1'b0;
      m_req_err   = 1'b0;
      return;
    end
    if (!m_active) begin
      if (request_byte) m_req_err = 1'b1;
      if (start) begin
        m_active    = 1'b1;
        m_init_need = 2;
        m_consumed  = '0;
      end
    end else if (m_init_need > 0) begin
      if (request_byte) m_req_err = 1'b1;
      if (m_q.size() > 0) begin
        b = m_q.pop_front();
        if (m_init_need == 2) m_init_value[15:8] = b;
        else begin
          m_init_value[7:0] = b;
          m_done = 1'b1;
        end
        m_init_need--;
        m_consumed++;
      end
    end else begin
      if (start) begin
        m_init_need = 2;
        m_pending   = 1'b0;
        m_consumed  = '0;
      end else if (want && m_q.size() > 0) begin
        b          = m_q.pop_front();
        m_byte_out = b;
        m_strobe   = 1'b1;
        m_pending  = 1'b0;
        m_consumed++;
      end else if (request_byte) begin
        m_pending = 1'b1;
      end
    end
    if (in_valid && can_push) m_q.push_back(in_byte);
  endfunction

  // One clock: check combinational outputs mid-cycle, step the model, then
  // check registered outputs just after the rising edge.
  task automatic tick();
    @(negedge clk);
    check("in_ready", in_ready, (m_q.size() < DEPTH));
    check("stall", stall, m_running() && (request_byte || m_pending) && (m_q.size() == 0));
    model_step();
    @(posedge clk);
    #1;
    check("byte_strobe", byte_strobe, m_strobe);
    check("byte_out", byte_out, m_byte_out);
    check("init_done", init_done, m_done);
    check("init_value", init_value, m_init_value);
    check("req_err", req_err, m_req_err);
    check("bytes_consumed", bytes_consumed, m_consumed);
  endtask

  task automatic drive(input bit f, input bit s, input bit v, input logic [7:0] b, input bit r);
    flush        = f;
    start        = s;
    in_valid     = v;
    in_byte      = b;
    request_byte = r;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_byte_out"}, byte_out, 0);
    check({tag, "_byte_strobe"}, byte_strobe, 0);
    check({tag, "_init_value"}, init_value, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_req_err"}, req_err, 0);
    check({tag, "_consumed"}, bytes_consumed, 0);
  endtask

  initial begin
    flush = 0; start = 0; in_valid = 0; in_byte = 0; request_byte = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Init sequence: init_done two cycles after start, value 0xA53C.
    drive(0, 0, 1, 8'hA5, 0);
    drive(0, 0, 1, 8'h3C, 0);
    drive(0, 1, 0, 8'h00, 0);
    idle();
    idle();
    check("init_done_t2", init_done, 1);
    check("init_value_a53c", init_value, 16'hA53C);
    check("init_consumed2", bytes_consumed, 2);

    // Steady supply: requests at t and t+3.
    drive(0, 0, 1, 8'h11, 0);
    drive(0, 0, 1, 8'h22, 0);
    drive(0, 0, 0, 8'h00, 1);
    check("steady_strobe1", byte_strobe, 1);
    check("steady_byte1", byte_out, 8'h11);
    idle();
    idle();
    drive(0, 0, 0, 8'h00, 1);
    check("steady_strobe2", byte_strobe, 1);
    check("steady_byte2", byte_out, 8'h22);

    // Underflow: request with empty FIFO, byte arrives 5 cycles later.
    request_byte = 1'b1;
    #1 check("uf_stall_t", stall, 1);
    tick();
    request_byte = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("uf_stall_hold", stall, 1);
      tick();
    end
    in_valid = 1'b1;
    in_byte  = 8'h7E;
    tick();
    in_valid = 1'b0;
    #1 check("uf_stall_clear", stall, 0);
    tick();
    check("uf_strobe", byte_strobe, 1);
    check("uf_byte", byte_out, 8'h7E);

    // Full FIFO, then request together with in_valid: pop only.
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 8'hB0 + 8'(i), 0);
    in_valid = 1'b0;
    #1 check("full_in_ready", in_ready, 0);
    drive(0, 0, 1, 8'h99, 1);
    check("full_pop_ready", in_ready, 1);
    check("full_pop_byte", byte_out, 8'hB0);
    for (int i = 1; i < DEPTH; i++) drive(0, 0, 0, 8'h00, 1);
    check("full_last_byte", byte_out, 8'hB3);
    request_byte = 1'b1;
    #1 check("full_drained_stall", stall, 1);
    tick();

    // Errors and flush.
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 1);
    check("req_err_idle", req_err, 1);
    drive(1, 0, 1, 8'hEE, 0);
    check("flush_req_err", req_err, 0);
    check("flush_in_ready", in_ready, 1);
    drive(0, 0, 1, 8'h55, 0);
    drive(0, 0, 1, 8'h66, 0);
    drive(0, 1, 0, 8'h00, 0);
    idle();
    idle();
    check("flush_no_store", init_value, 16'h5566);

    // Async reset while in INIT1 with three bytes queued.
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 8'h10 * 8'(i + 1), 0);
    drive(0, 1, 0, 8'h00, 0);
    idle();
    flush = 0; start = 0; in_valid = 0; request_byte = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 1, 8'h01, 0);
    drive(0, 0, 1, 8'h02, 0);
    drive(0, 1, 0, 8'h00, 0);
    idle();
    idle();
    check("post_rst_init", init_value, 16'h0102);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 64) == 0, ($urandom % 40) == 0, ($urandom % 2) == 0,
            8'($urandom), ($urandom % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
